// File: rtl/regfile_multiport.sv
// regfile_multiport: two-write, NUM_READ-read register file with busy scoreboard; `REGFILE_BYPASS_EN adds write-to-read bypass
module regfile_multiport #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                           clock,
    input  logic                           ctrl_reset_n,
    input  logic [1:0]                     ctrl_writeEn,
    input  logic [2*AW-1:0]                ctrl_writeReg,
    input  logic [2*DATA_WIDTH-1:0]        data_writeReg,
    input  logic [NUM_READ*AW-1:0]         ctrl_readReg,
    output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
    input  logic                           ctrl_busySet,
    input  logic [AW-1:0]                  ctrl_busyReg,
    output logic [NUM_READ-1:0]            data_busy
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_busy;
    logic [DEPTH-1:0]      w_hit0;
    logic [DEPTH-1:0]      w_hit1;
    logic [DEPTH-1:0]      w_set;
    logic [AW-1:0]         w_ridx [NUM_READ];

    function automatic logic f_valid(input logic [AW-1:0] idx);
        return (int'(idx) < DEPTH) && !((ZERO_REG != 0) && (idx == '0));
    endfunction

    // one-hot per-register write/set strobes; gated by reset so a held reset shows nothing
    always_comb begin
        w_hit0 = '0;
        w_hit1 = '0;
        w_set  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_hit0[i] = ctrl_reset_n && ctrl_writeEn[0] && f_valid(ctrl_writeReg[0 +: AW]) && (ctrl_writeReg[0 +: AW] == AW'(i));
            w_hit1[i] = ctrl_reset_n && ctrl_writeEn[1] && f_valid(ctrl_writeReg[AW +: AW]) && (ctrl_writeReg[AW +: AW] == AW'(i));
            w_set[i]  = ctrl_reset_n && ctrl_busySet && f_valid(ctrl_busyReg) && (ctrl_busyReg == AW'(i));
        end
    end

    // storage and scoreboard: port 1 beats port 0, a new producer's set beats a writeback clear
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_hit1[i]) r_mem[i] <= data_writeReg[DATA_WIDTH +: DATA_WIDTH];
                else if (w_hit0[i]) r_mem[i] <= data_writeReg[0 +: DATA_WIDTH];
                if (w_set[i]) r_busy[i] <= 1'b1;
                else if (w_hit0[i] || w_hit1[i]) r_busy[i] <= 1'b0;
            end
        end
    end

    // unpack read indices
    always_comb begin
        for (int p = 0; p < NUM_READ; p++) w_ridx[p] = ctrl_readReg[p*AW +: AW];
    end

    // combinational read ports; invalid indices and the zero register read 0
    always_comb begin
        data_readReg = '0;
        data_busy    = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            if (f_valid(w_ridx[p])) begin
                data_readReg[p*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_ridx[p]];
                data_busy[p] = r_busy[w_ridx[p]];
`ifdef REGFILE_BYPASS_EN
                if (w_hit1[w_ridx[p]]) data_readReg[p*DATA_WIDTH +: DATA_WIDTH] = data_writeReg[DATA_WIDTH +: DATA_WIDTH];
                else if (w_hit0[w_ridx[p]]) data_readReg[p*DATA_WIDTH +: DATA_WIDTH] = data_writeReg[0 +: DATA_WIDTH];
                if (w_set[w_ridx[p]]) data_busy[p] = 1'b1;
                else if (w_hit0[w_ridx[p]] || w_hit1[w_ridx[p]]) data_busy[p] = 1'b0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: default and DEPTH=24/NUM_READ=4 instances checked every cycle against an array model
module tb_regfile_multiport;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         rst_n;
    logic [1:0]   wen;
    logic [9:0]   wreg;
    logic [63:0]  wdata;
    logic         bset;
    logic [4:0]   breg;
    logic [9:0]   rreg_a;
    logic [63:0]  rdata_a;
    logic [1:0]   busy_a;
    logic [19:0]  rreg_b;
    logic [127:0] rdata_b;
    logic [3:0]   busy_b;

    regfile_multiport u_a (
        .clock(clock), .ctrl_reset_n(rst_n), .ctrl_writeEn(wen), .ctrl_writeReg(wreg),
        .data_writeReg(wdata), .ctrl_readReg(rreg_a), .data_readReg(rdata_a),
        .ctrl_busySet(bset), .ctrl_busyReg(breg), .data_busy(busy_a)
    );

    regfile_multiport #(.DEPTH(24), .NUM_READ(4)) u_b (
        .clock(clock), .ctrl_reset_n(rst_n), .ctrl_writeEn(wen), .ctrl_writeReg(wreg),
        .data_writeReg(wdata), .ctrl_readReg(rreg_b), .data_readReg(rdata_b),
        .ctrl_busySet(bset), .ctrl_busyReg(breg), .data_busy(busy_b)
    );

    logic [31:0] m_mem  [2][32];
    logic        m_busy [2][32];
    int n_run = 0;
    int n_fail = 0;
    logic        lit_en = 1'b0;
    int          lit_inst = 0;
    logic [31:0] lit_d = '0;
    logic        lit_b = 1'b0;
    logic        lit_cb = 1'b0;

    function automatic logic ok(input int m, input int idx);
        return idx != 0 && idx < (m == 0 ? 32 : 24);
    endfunction

    function automatic logic [31:0] exp_rd(input int m, input int idx);
        if (!rst_n || !ok(m, idx)) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (wen[1] && int'(wreg[9:5]) == idx) return wdata[63:32];
        if (wen[0] && int'(wreg[4:0]) == idx) return wdata[31:0];
`endif
        return m_mem[m][idx];
    endfunction

    function automatic logic exp_bz(input int m, input int idx);
        if (!rst_n || !ok(m, idx)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (bset && int'(breg) == idx) return 1'b1;
        if ((wen[1] && int'(wreg[9:5]) == idx) || (wen[0] && int'(wreg[4:0]) == idx)) return 1'b0;
`endif
        return m_busy[m][idx];
    endfunction

    // reference model: array of registers plus busy flags per instance
    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++)
                for (int i = 0; i < 32; i++) begin
                    m_mem[m][i] <= '0;
                    m_busy[m][i] <= 1'b0;
                end
        end else begin
            for (int m = 0; m < 2; m++) begin
                for (int k = 0; k < 2; k++)
                    if (wen[k] && ok(m, int'(wreg[k*5 +: 5]))) begin
                        m_mem[m][wreg[k*5 +: 5]] <= wdata[k*32 +: 32];
                        m_busy[m][wreg[k*5 +: 5]] <= 1'b0;
                    end
                if (bset && ok(m, int'(breg))) m_busy[m][breg] <= 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // single compare process: every port of both instances each cycle, plus literal pins
    always @(negedge clock) begin
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("rd_a%0d", p), rdata_a[p*32 +: 32], exp_rd(0, int'(rreg_a[p*5 +: 5])));
            chk($sformatf("busy_a%0d", p), {31'b0, busy_a[p]}, {31'b0, exp_bz(0, int'(rreg_a[p*5 +: 5]))});
        end
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("rd_b%0d", p), rdata_b[p*32 +: 32], exp_rd(1, int'(rreg_b[p*5 +: 5])));
            chk($sformatf("busy_b%0d", p), {31'b0, busy_b[p]}, {31'b0, exp_bz(1, int'(rreg_b[p*5 +: 5]))});
        end
        if (lit_en) begin
            chk("lit_rd", lit_inst == 0 ? rdata_a[31:0] : rdata_b[31:0], lit_d);
            if (lit_cb) chk("lit_busy", {31'b0, lit_inst == 0 ? busy_a[0] : busy_b[0]}, {31'b0, lit_b});
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
        lit_en = 1'b0;
    endtask

    task automatic idle();
        wen = 2'b00;
        bset = 1'b0;
    endtask

    task automatic lit(input int inst, input logic [31:0] d, input logic b, input logic cb);
        lit_inst = inst;
        lit_d = d;
        lit_b = b;
        lit_cb = cb;
        lit_en = 1'b1;
    endtask

    function automatic logic [4:0] ri();
        return ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
    endfunction

    initial begin
        rst_n = 1'b0; wen = '0; wreg = '0; wdata = '0; bset = 1'b0; breg = '0; rreg_a = '0; rreg_b = '0;
        repeat (3) cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rreg_a = {2{5'(i)}}; rreg_b = {4{5'(i)}};
            lit(0, 32'h0, 1'b0, 1'b1);
            cyc();
        end
        for (int i = 0; i < 32; i++) begin
            wen = 2'b01; wreg = {5'd0, 5'(i)}; wdata = {32'h0, 32'h0000DEAD + 32'(i)};
            rreg_a = {2{5'(i)}}; rreg_b = {4{5'(i)}};
            cyc();
        end
        idle();
        rreg_a = {2{5'd0}}; lit(0, 32'h0, 1'b0, 1'b1); cyc();
        rreg_a = {2{5'd5}}; lit(0, 32'h0000DEB2, 1'b0, 1'b1); cyc();
        rreg_a = {2{5'd31}}; lit(0, 32'h0000DECC, 1'b0, 1'b1); cyc();
        rreg_b = {4{5'd23}}; lit(1, 32'h0000DEC4, 1'b0, 1'b1); cyc();
        rreg_b = {4{5'd30}}; lit(1, 32'h0, 1'b0, 1'b1); cyc();
        wen = 2'b11; wreg = {5'd5, 5'd5}; wdata = {32'h22222222, 32'h11111111}; cyc();
        idle(); rreg_a = {2{5'd5}}; lit(0, 32'h22222222, 1'b0, 1'b1); cyc();
        bset = 1'b1; breg = 5'd7; cyc();
        bset = 1'b0; rreg_a = {2{5'd7}}; lit(0, 32'h0000DEB4, 1'b1, 1'b1); cyc();
        wen = 2'b01; wreg = {5'd0, 5'd7}; wdata = {32'h0, 32'h77}; bset = 1'b1; breg = 5'd7; cyc();
        idle(); lit(0, 32'h77, 1'b1, 1'b1); cyc();
        wen = 2'b01; wreg = {5'd0, 5'd7}; wdata = {32'h0, 32'h78}; cyc();
        idle(); lit(0, 32'h78, 1'b0, 1'b1); cyc();
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        wen = 2'b01; wreg = {5'd0, 5'd3}; wdata = {32'h0, 32'hCAFEF00D}; rreg_a = {2{5'd3}};
`ifdef REGFILE_BYPASS_EN
        lit(0, 32'hCAFEF00D, 1'b0, 1'b1);
`else
        lit(0, 32'h0, 1'b0, 1'b1);
`endif
        cyc();
        idle(); lit(0, 32'hCAFEF00D, 1'b0, 1'b1); cyc();
        wen = 2'b01; wreg = {5'd0, 5'd30}; wdata = {32'h0, 32'hBADBAD00}; bset = 1'b1; breg = 5'd30;
        rreg_b = {4{5'd30}}; lit(1, 32'h0, 1'b0, 1'b1); cyc();
        idle(); lit(1, 32'h0, 1'b0, 1'b1); cyc();
        wen = 2'b01; wreg = {5'd0, 5'd4}; wdata = {32'h0, 32'h12345678}; cyc();
        idle(); rreg_a = {2{5'd4}}; rreg_b = {4{5'd4}}; lit(1, 32'h12345678, 1'b0, 1'b1); cyc();
        lit(1, 32'h0, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        @(negedge clock);
        #1 rst_n = 1'b1;
        @(posedge clock);
        #1 lit_en = 1'b0;
        lit(0, 32'h0, 1'b0, 1'b1); cyc();
        wen = 2'b01; wreg = {5'd0, 5'd9}; wdata = {32'h0, 32'h99};
        #1 rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; idle(); rreg_a = {2{5'd9}}; lit(0, 32'h0, 1'b0, 1'b1); cyc();
        repeat (500) begin
            rst_n = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
            wen = 2'($urandom); wreg = {ri(), ri()}; wdata = {$urandom, $urandom};
            bset = 1'($urandom); breg = ri();
            rreg_a = {ri(), ri()}; rreg_b = {ri(), ri(), ri(), ri()};
            cyc();
        end
        rst_n = 1'b1; idle();
        cyc(); cyc();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
